// File: rtl/perf_cnt_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_cnt_pkg;

    typedef enum logic [1:0] {
        PERF_IDLE   = 2'd0,
        PERF_COUNT  = 2'd1,
        PERF_FROZEN = 2'd2
    } perf_state_t;

    localparam int PERF_NUM_EVENTS = 8;
    localparam int PERF_CNT_WIDTH  = 32;

    localparam int EV_CYCLE   = 0;
    localparam int EV_STALL   = 1;
    localparam int EV_BR      = 2;
    localparam int EV_MISPRED = 3;
    localparam int EV_PMEM_RD = 4;
    localparam int EV_PMEM_WR = 5;

    // A single-channel bank still needs a one-bit select port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with wrap-or-saturate behaviour and a sticky overflow flag.
module perf_counter_cell #(
    parameter int CNT_WIDTH = 32,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 at_max;

    assign at_max = &count_q;

    // Overflow is flagged on any increment attempted at all-ones, in both modes.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (inc) begin
            ovf_d = ovf_q | at_max;
            if (!(at_max && (SATURATE != 0))) begin
                count_d = count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with IDLE/COUNT/FROZEN control and a one-outstanding read port.
// Define PERF_CNT_SNAPSHOT_EN to add a snap input and shadow registers that reads return.
module perf_counter_bank
    import perf_cnt_pkg::*;
#(
    parameter  int NUM_EVENTS = PERF_NUM_EVENTS,
    parameter  int CNT_WIDTH  = PERF_CNT_WIDTH,
    parameter  int SATURATE   = 0,
    localparam int SEL_W      = sel_width(NUM_EVENTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  halt,
    input  logic [NUM_EVENTS-1:0] event_i,
`ifdef PERF_CNT_SNAPSHOT_EN
    input  logic                  snap,
`endif
    input  logic                  rd_req,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic                  rd_valid,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_err,
    output logic [NUM_EVENTS-1:0] overflow,
    output logic                  frozen
);

    perf_state_t state_q, state_d;
    logic        count_en;

    logic [CNT_WIDTH-1:0] cnt     [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] rd_src  [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] ovf;

    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_err_q, rd_err_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 accept;
    logic                 sel_hit;
    logic [CNT_WIDTH-1:0] sel_val;

    // clear beats halt beats normal enable-driven transitions.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = PERF_IDLE;
        end else if (halt) begin
            state_d = PERF_FROZEN;
        end else begin
            case (state_q)
                PERF_IDLE:  if (enable)  state_d = PERF_COUNT;
                PERF_COUNT: if (!enable) state_d = PERF_IDLE;
                default:    state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PERF_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign count_en = (state_q == PERF_COUNT) && enable && !clear && !halt;
    assign frozen   = (state_q == PERF_FROZEN);

    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .SATURATE  (SATURATE)
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .inc   (count_en && event_i[g]),
            .clr   (clear),
            .count (cnt[g]),
            .ovf   (ovf[g])
        );
    end

    assign overflow = ovf;

`ifdef PERF_CNT_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] shadow_q [NUM_EVENTS];
    logic [CNT_WIDTH-1:0] shadow_d [NUM_EVENTS];
    logic                 capture;

    // Shadows also capture on the edge that enters FROZEN, so a halted bank reads back its final counts.
    assign capture = snap || (halt && (state_q != PERF_FROZEN));

    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (clear) begin
                shadow_d[i] = '0;
            end else if (capture) begin
                shadow_d[i] = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            rd_src[i] = shadow_q[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) begin
            rd_src[i] = cnt[i];
        end
    end
`endif

    // Reads sample the registered value, so a read in a clear or increment cycle sees the old count.
    always_comb begin
        sel_hit = 1'b0;
        sel_val = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_hit = 1'b1;
                sel_val = rd_src[i];
            end
        end
        accept     = rd_req && !rd_valid_q;
        rd_valid_d = accept;
        rd_err_d   = accept && !sel_hit;
        rd_data_d  = rd_data_q;
        if (accept) begin
            rd_data_d = sel_hit ? sel_val : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench for perf_counter_bank: a wrapping and a saturating instance share stimulus.
module tb_perf_counter_bank;
    import perf_cnt_pkg::*;

    localparam int NE   = 6;
    localparam int CW   = 8;
    localparam int SW   = 3;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable, clear, halt, rd_req;
    logic [NE-1:0] event_i;
    logic [SW-1:0] rd_sel;
`ifdef PERF_CNT_SNAPSHOT_EN
    logic          snap;
`endif

    logic          rd_valid_w, rd_err_w, frozen_w;
    logic [CW-1:0] rd_data_w;
    logic [NE-1:0] overflow_w;
    logic          rd_valid_s, rd_err_s, frozen_s;
    logic [CW-1:0] rd_data_s;
    logic [NE-1:0] overflow_s;

    int n_checks = 0;
    int n_fail   = 0;
    string phase = "init";

    // Reference model: plain per-channel counts and mode flags.
    int unsigned m_w    [NE];
    int unsigned m_s    [NE];
    int unsigned m_sh_w [NE];
    int unsigned m_sh_s [NE];
    bit [NE-1:0] m_ovf_w, m_ovf_s;
    bit          m_frozen, m_counting, m_rdv, m_err;
    int unsigned m_data_w, m_data_s;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .halt(halt), .event_i(event_i),
`ifdef PERF_CNT_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid_w), .rd_data(rd_data_w),
        .rd_err(rd_err_w), .overflow(overflow_w), .frozen(frozen_w)
    );

    perf_counter_bank #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear), .halt(halt), .event_i(event_i),
`ifdef PERF_CNT_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid_s), .rd_data(rd_data_s),
        .rd_err(rd_err_s), .overflow(overflow_s), .frozen(frozen_s)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic checkCycle();
        checkOutput("rd_valid_w", 64'(rd_valid_w), 64'(m_rdv));
        checkOutput("rd_valid_s", 64'(rd_valid_s), 64'(m_rdv));
        checkOutput("rd_err_w",   64'(rd_err_w),   64'(m_err));
        checkOutput("rd_err_s",   64'(rd_err_s),   64'(m_err));
        checkOutput("rd_data_w",  64'(rd_data_w),  64'(m_data_w));
        checkOutput("rd_data_s",  64'(rd_data_s),  64'(m_data_s));
        checkOutput("overflow_w", 64'(overflow_w), 64'(m_ovf_w));
        checkOutput("overflow_s", 64'(overflow_s), 64'(m_ovf_s));
        checkOutput("frozen_w",   64'(frozen_w),   64'(m_frozen));
        checkOutput("frozen_s",   64'(frozen_s),   64'(m_frozen));
    endtask

    task automatic resetModel();
        for (int i = 0; i < NE; i++) begin
            m_w[i] = 0; m_s[i] = 0; m_sh_w[i] = 0; m_sh_s[i] = 0;
        end
        m_ovf_w = '0; m_ovf_s = '0;
        m_frozen = 0; m_counting = 0; m_rdv = 0; m_err = 0;
        m_data_w = 0; m_data_s = 0;
    endtask

    // One clock of stimulus; the model advances using the values present before the edge.
    task automatic applyStimulus(input bit en, input bit cl, input bit hl, input bit [NE-1:0] ev,
                                 input bit rq, input bit [SW-1:0] sel, input bit sn);
        bit accept, cnt_now, capture;
        enable = en; clear = cl; halt = hl; event_i = ev; rd_req = rq; rd_sel = sel;
`ifdef PERF_CNT_SNAPSHOT_EN
        snap = sn;
`endif
        accept = rq && !m_rdv;
        m_err  = accept && (int'(sel) >= NE);
        if (accept) begin
            if (int'(sel) < NE) begin
`ifdef PERF_CNT_SNAPSHOT_EN
                m_data_w = m_sh_w[sel]; m_data_s = m_sh_s[sel];
`else
                m_data_w = m_w[sel];    m_data_s = m_s[sel];
`endif
            end else begin
                m_data_w = 0; m_data_s = 0;
            end
        end
        m_rdv = accept;

        capture = sn || (hl && !m_frozen);
        for (int i = 0; i < NE; i++) begin
            m_sh_w[i] = cl ? 0 : (capture ? m_w[i] : m_sh_w[i]);
            m_sh_s[i] = cl ? 0 : (capture ? m_s[i] : m_sh_s[i]);
        end

        cnt_now = m_counting && en && !cl && !hl;
        for (int i = 0; i < NE; i++) begin
            if (cl) begin
                m_w[i] = 0; m_s[i] = 0; m_ovf_w[i] = 0; m_ovf_s[i] = 0;
            end else if (cnt_now && ev[i]) begin
                if (m_w[i] == MAXV) m_ovf_w[i] = 1;
                m_w[i] = (m_w[i] + 1) % (MAXV + 1);
                if (m_s[i] == MAXV) m_ovf_s[i] = 1;
                else m_s[i] = m_s[i] + 1;
            end
        end

        if (cl) begin
            m_frozen = 0; m_counting = 0;
        end else if (hl) begin
            m_frozen = 1; m_counting = 0;
        end else if (!m_frozen) begin
            m_counting = en;
        end

        @(posedge clk);
        #1;
        checkCycle();
    endtask

    task automatic doReset();
        rst = 1'b1;
        enable = 0; clear = 0; halt = 0; event_i = '0; rd_req = 0; rd_sel = '0;
`ifdef PERF_CNT_SNAPSHOT_EN
        snap = 0;
`endif
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        checkCycle();
        rst = 1'b0;
    endtask

    task automatic countEvents(input int n, input bit [NE-1:0] ev);
        for (int k = 0; k < n; k++) applyStimulus(1, 0, 0, ev, 0, '0, 0);
    endtask

    task automatic freshStart();
        applyStimulus(0, 1, 0, '0, 0, '0, 0);
        applyStimulus(1, 0, 0, '0, 0, '0, 0);
    endtask

    initial begin
        $display("[TB] starting perf_counter_bank bench");

        phase = "reset";
        doReset();

        phase = "basic";
        applyStimulus(1, 0, 0, '0, 0, '0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 0, 0, NE'(1) | ((k % 2 == 0) ? NE'(4) : NE'(0)), 0, '0, 0);
        end
`ifdef PERF_CNT_SNAPSHOT_EN
        applyStimulus(1, 0, 0, '0, 0, '0, 1);
`endif
        applyStimulus(1, 0, 0, '0, 1, 3'd0, 0);
        checkOutput("tp_ch0_eq_10", 64'(rd_data_w), 64'd10);
        applyStimulus(1, 0, 0, '0, 0, '0, 0);
        applyStimulus(1, 0, 0, '0, 1, 3'd2, 0);
        checkOutput("tp_ch2_eq_5", 64'(rd_data_w), 64'd5);
        checkOutput("tp_no_ovf", 64'(overflow_w), 64'd0);
        applyStimulus(1, 0, 0, '0, 0, '0, 0);

        phase = "random";
        for (int k = 0; k < 120; k++) begin
            int r;
            r = int'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 7) != 0, r == 0, r == 1, NE'($urandom),
                          1'($urandom_range(0, 1)), SW'($urandom_range(0, 7)),
                          $urandom_range(0, 9) == 0);
        end

        phase = "wrap_sat";
        freshStart();
        countEvents(257, NE'(2));
        applyStimulus(1, 0, 0, '0, 1, 3'd1, 0);
        checkOutput("tp_wrap_data", 64'(rd_data_w), 64'd1);
        checkOutput("tp_sat_data", 64'(rd_data_s), 64'd255);
        checkOutput("tp_wrap_ovf1", 64'(overflow_w[1]), 64'd1);
        checkOutput("tp_sat_ovf1", 64'(overflow_s[1]), 64'd1);
        applyStimulus(1, 0, 0, '0, 0, '0, 0);

        phase = "halt";
        freshStart();
        countEvents(7, NE'(8));
        applyStimulus(1, 0, 1, NE'(8), 0, '0, 0);
        countEvents(5, NE'(8));
        checkOutput("tp_frozen", 64'(frozen_w), 64'd1);
        applyStimulus(1, 0, 0, '0, 1, 3'd3, 0);
        checkOutput("tp_frozen_read", 64'(rd_data_w), 64'd7);
        applyStimulus(0, 1, 0, '0, 0, '0, 0);
        checkOutput("tp_unfrozen", 64'(frozen_w), 64'd0);
        applyStimulus(0, 0, 0, '0, 1, 3'd3, 0);
        checkOutput("tp_cleared_read", 64'(rd_data_w), 64'd0);
        checkOutput("tp_cleared_ovf", 64'(overflow_s), 64'd0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0);

        phase = "clear_halt";
        freshStart();
        countEvents(9, NE'(1));
        applyStimulus(1, 1, 1, NE'(1), 0, '0, 0);
        checkOutput("tp_ch_frozen", 64'(frozen_w), 64'd0);
        applyStimulus(0, 0, 0, '0, 1, 3'd0, 0);
        checkOutput("tp_ch_read", 64'(rd_data_w), 64'd0);
        applyStimulus(1, 0, 0, '0, 0, '0, 0);
        countEvents(2, NE'(1));
`ifdef PERF_CNT_SNAPSHOT_EN
        applyStimulus(1, 0, 0, '0, 0, '0, 1);
`endif
        applyStimulus(1, 0, 0, '0, 1, 3'd0, 0);
        checkOutput("tp_ch_recount", 64'(rd_data_w), 64'd2);
        applyStimulus(0, 0, 0, '0, 0, '0, 0);

        phase = "rd_hold";
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, '0, 1, 3'd0, 0);
            checkOutput("tp_rdv_pattern", 64'(rd_valid_w), (k % 2 == 0) ? 64'd1 : 64'd0);
        end
        applyStimulus(0, 0, 0, '0, 0, '0, 0);
        applyStimulus(0, 0, 0, '0, 1, 3'(NE), 0);
        checkOutput("tp_rd_err", 64'(rd_err_w), 64'd1);
        checkOutput("tp_rd_err_data", 64'(rd_data_w), 64'd0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0);

        phase = "rst_mid_read";
        freshStart();
        countEvents(3, NE'(1));
`ifdef PERF_CNT_SNAPSHOT_EN
        applyStimulus(1, 0, 0, '0, 0, '0, 1);
`endif
        applyStimulus(1, 0, 0, '0, 1, 3'd0, 0);
        checkOutput("tp_pre_rst_data", 64'(rd_data_w), 64'd3);
        #1 rst = 1'b1;
        resetModel();
        #1;
        checkOutput("tp_async_rdv_w", 64'(rd_valid_w), 64'd0);
        checkOutput("tp_async_rdv_s", 64'(rd_valid_s), 64'd0);
        checkOutput("tp_async_data", 64'(rd_data_w), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1, 0, 0, '0, 1, 3'd0, 0);
        checkOutput("tp_post_rst_cnt", 64'(rd_data_w), 64'd0);
        applyStimulus(1, 0, 0, '0, 0, '0, 0);

        phase = "snapshot";
        freshStart();
        countEvents(4, NE'(1));
        applyStimulus(1, 0, 0, '0, 0, '0, 1);
        countEvents(3, NE'(1));
        applyStimulus(1, 0, 0, '0, 1, 3'd0, 0);
`ifdef PERF_CNT_SNAPSHOT_EN
        checkOutput("tp_snap_read", 64'(rd_data_w), 64'd4);
`else
        checkOutput("tp_live_read", 64'(rd_data_w), 64'd7);
`endif
        applyStimulus(0, 0, 0, '0, 0, '0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
